// File: rtl/multi_channel_arbitration_unit.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_arbitration_unit
// Brief    : Arbitrates local channels onto a tagged master link and demuxes
//            tagged inbound words back to the channels, via two FWFT FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
module multi_channel_arbitration_unit #(
   parameter int NUM_CHANNELS = 2,
   parameter int MSG_WIDTH    = 14,
   parameter int HEADER_WIDTH = 4,
   parameter int FIFO_DEPTH   = 16,
   parameter int ROUND_ROBIN  = 1,
   localparam int CH_W             = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
   localparam int FINAL_FIFO_WIDTH = HEADER_WIDTH + CH_W + MSG_WIDTH
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_CHANNELS*MSG_WIDTH-1:0]    local_out_data,
   input  logic [NUM_CHANNELS-1:0]              local_out_valid,
   output logic [NUM_CHANNELS-1:0]              local_out_ready,
   output logic [NUM_CHANNELS*MSG_WIDTH-1:0]    local_in_data,
   output logic [NUM_CHANNELS-1:0]              local_in_valid,
   input  logic [NUM_CHANNELS-1:0]              local_in_ready,
   input  logic [NUM_CHANNELS*HEADER_WIDTH-1:0] receiver_id,
   output logic [FINAL_FIFO_WIDTH-1:0]          master_fifo_out_data,
   output logic                                 master_fifo_out_valid,
   input  logic                                 master_fifo_out_ready,
   input  logic [FINAL_FIFO_WIDTH-1:0]          master_fifo_in_data,
   input  logic                                 master_fifo_in_valid,
   output logic                                 master_fifo_in_ready,
   output logic                                 has_flying_messages,
   output logic [15:0]                          drop_count
);

   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = ADDR_W + 1;

   // ---------------------------------------------------------------- outbound
   logic [FINAL_FIFO_WIDTH-1:0] r_out_mem [FIFO_DEPTH];
   logic [ADDR_W-1:0]           r_out_wr_ptr;
   logic [ADDR_W-1:0]           r_out_rd_ptr;
   logic [CNT_W-1:0]            r_out_count;
   logic                        w_out_full;
   logic                        w_out_empty;
   logic                        w_out_wr;
   logic                        w_out_rd;
   logic [FINAL_FIFO_WIDTH-1:0] w_out_word;

   logic [CH_W-1:0]             r_rr_ptr;
   logic [CH_W-1:0]             w_grant_idx;
   logic                        w_grant_any;

   // Depth is a power of two, so the count MSB alone marks "full".
   assign w_out_full  = r_out_count[ADDR_W];
   assign w_out_empty = (r_out_count == '0);
   assign w_out_wr    = w_grant_any & ~w_out_full;
   assign w_out_rd    = master_fifo_out_ready & ~w_out_empty;

   always_comb begin : p_arb
      int idx;
      idx         = 0;
      w_grant_any = 1'b0;
      w_grant_idx = '0;
      if (ROUND_ROBIN != 0) begin
         for (int k = 0; k < NUM_CHANNELS; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
            if (!w_grant_any && local_out_valid[idx]) begin
               w_grant_any = 1'b1;
               w_grant_idx = CH_W'(idx);
            end
         end
      end else begin
         for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
            if (local_out_valid[k]) begin
               w_grant_any = 1'b1;
               w_grant_idx = CH_W'(k);
            end
         end
      end
   end

   always_comb begin
      local_out_ready = '0;
      if (w_out_wr) local_out_ready[w_grant_idx] = 1'b1;
   end

   assign w_out_word = {receiver_id[w_grant_idx*HEADER_WIDTH +: HEADER_WIDTH],
                        w_grant_idx,
                        local_out_data[w_grant_idx*MSG_WIDTH +: MSG_WIDTH]};

   always_ff @(posedge clk) begin
      if (w_out_wr) r_out_mem[r_out_wr_ptr] <= w_out_word;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_wr_ptr <= '0;
         r_out_rd_ptr <= '0;
         r_out_count  <= '0;
         r_rr_ptr     <= '0;
      end else begin
         if (w_out_wr) begin
            r_out_wr_ptr <= r_out_wr_ptr + ADDR_W'(1);
            r_rr_ptr     <= (int'(w_grant_idx) == NUM_CHANNELS - 1) ? '0
                                                                    : w_grant_idx + CH_W'(1);
         end
         if (w_out_rd) r_out_rd_ptr <= r_out_rd_ptr + ADDR_W'(1);
         case ({w_out_wr, w_out_rd})
            2'b10:   r_out_count <= r_out_count + CNT_W'(1);
            2'b01:   r_out_count <= r_out_count - CNT_W'(1);
            default: r_out_count <= r_out_count;
         endcase
      end
   end

   assign master_fifo_out_data  = r_out_mem[r_out_rd_ptr];
   assign master_fifo_out_valid = ~w_out_empty;

   // ----------------------------------------------------------------- inbound
   logic [FINAL_FIFO_WIDTH-1:0] r_in_mem [FIFO_DEPTH];
   logic [ADDR_W-1:0]           r_in_wr_ptr;
   logic [ADDR_W-1:0]           r_in_rd_ptr;
   logic [CNT_W-1:0]            r_in_count;
   logic                        w_in_full;
   logic                        w_in_empty;
   logic                        w_in_wr;
   logic                        w_in_rd;
   logic [FINAL_FIFO_WIDTH-1:0] w_in_head;
   logic [CH_W-1:0]             w_in_tag;
   logic                        w_in_tag_ok;
   logic                        w_in_drop;
   logic                        w_unused_hdr;
   logic [15:0]                 r_drop_count;

   assign w_in_full    = r_in_count[ADDR_W];
   assign w_in_empty   = (r_in_count == '0);
   assign w_in_wr      = master_fifo_in_valid & ~w_in_full;
   assign w_in_head    = r_in_mem[r_in_rd_ptr];
   assign w_in_tag     = w_in_head[MSG_WIDTH +: CH_W];
   assign w_in_tag_ok  = (int'(w_in_tag) < NUM_CHANNELS);
   // The receiver-id field is meaningless on the way in.
   assign w_unused_hdr = ^w_in_head[FINAL_FIFO_WIDTH-1 : CH_W+MSG_WIDTH];

   generate
      for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_in_slice
         assign local_in_valid[i] = ~w_in_empty & w_in_tag_ok & (w_in_tag == CH_W'(i));
         assign local_in_data[i*MSG_WIDTH +: MSG_WIDTH] = w_in_head[MSG_WIDTH-1:0];
      end
   endgenerate

   // Out-of-range tags are discarded without waiting on any channel.
   assign w_in_drop = ~w_in_empty & ~w_in_tag_ok;
   assign w_in_rd   = (|(local_in_valid & local_in_ready)) | w_in_drop;

   always_ff @(posedge clk) begin
      if (w_in_wr) r_in_mem[r_in_wr_ptr] <= master_fifo_in_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_in_wr_ptr  <= '0;
         r_in_rd_ptr  <= '0;
         r_in_count   <= '0;
         r_drop_count <= '0;
      end else begin
         if (w_in_wr) r_in_wr_ptr <= r_in_wr_ptr + ADDR_W'(1);
         if (w_in_rd) r_in_rd_ptr <= r_in_rd_ptr + ADDR_W'(1);
         case ({w_in_wr, w_in_rd})
            2'b10:   r_in_count <= r_in_count + CNT_W'(1);
            2'b01:   r_in_count <= r_in_count - CNT_W'(1);
            default: r_in_count <= r_in_count;
         endcase
         if (w_in_drop && (r_drop_count != 16'hFFFF))
            r_drop_count <= r_drop_count + 16'd1;
      end
   end

   assign master_fifo_in_ready = ~w_in_full;
   assign drop_count           = r_drop_count;
   assign has_flying_messages  = (|local_out_valid) | (|local_in_valid)
                               | ~w_out_empty | ~w_in_empty;

endmodule
`default_nettype wire
